// File: rtl/nrst_sequencer.sv
// Multi-channel reset sequencer: asynchronous assert, synchronised negate, then
// timed thermometer release of CHANNELS active-low resets. Optional soft reset: NRST_SEQ_SWRST_EN.
module nrst_sequencer #(
  parameter int STAGES      = 2,
  parameter int CHANNELS    = 4,
  parameter int HOLD_CYCLES = 16,
  parameter int STEP_CYCLES = 8
) (
  input  logic                CLK_I,
  input  logic                NRST_I,
`ifdef NRST_SEQ_SWRST_EN
  input  logic                SWRST_I,
`endif
  output logic [CHANNELS-1:0] NRST_O,
  output logic                RST_DONE_O
);

  localparam int MAX_CYC = (HOLD_CYCLES > STEP_CYCLES) ? HOLD_CYCLES : STEP_CYCLES;
  localparam int CNT_W   = (MAX_CYC < 1) ? 1 : $clog2(MAX_CYC + 1);
  localparam int IDX_W   = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

  typedef enum logic [1:0] {
    ST_ASSERT = 2'd0,
    ST_HOLD   = 2'd1,
    ST_STEP   = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  if (STAGES < 2) begin : g_bad_stages
    $error("nrst_sequencer: STAGES must be >= 2");
  end
  if (CHANNELS < 1) begin : g_bad_channels
    $error("nrst_sequencer: CHANNELS must be >= 1");
  end
  if (STEP_CYCLES < 1) begin : g_bad_step
    $error("nrst_sequencer: STEP_CYCLES must be >= 1");
  end

  logic [STAGES-1:0]   r_sync;
  state_t              r_state;
  state_t              w_state_nxt;
  logic [CNT_W-1:0]    r_cnt;
  logic [CNT_W-1:0]    w_cnt_nxt;
  logic [IDX_W-1:0]    r_idx;
  logic [IDX_W-1:0]    w_idx_nxt;
  logic [CHANNELS-1:0] r_nrst;
  logic [CHANNELS-1:0] w_nrst_nxt;
  logic                r_done;
  logic                w_done_nxt;
  logic [CHANNELS:0]   w_nrst_shift;
  logic                w_sync_n;
  logic                w_hold_end;
  logic                w_step_end;
  logic                w_last_ch;

  // Reset synchroniser: async clear, shifts ones in after NRST_I negates.
  always_ff @(posedge CLK_I or negedge NRST_I) begin
    if (!NRST_I) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[STAGES-2:0], 1'b1};
    end
  end

  assign w_sync_n     = r_sync[STAGES-1];
  // Shifting a 1 in from the bottom keeps the outputs thermometer-coded.
  assign w_nrst_shift = {r_nrst, 1'b1};
  assign w_hold_end   = (int'(r_cnt) + 32'sd1) >= HOLD_CYCLES;
  assign w_step_end   = (int'(r_cnt) + 32'sd1) >= STEP_CYCLES;
  assign w_last_ch    = (int'(r_idx) + 32'sd2) >= CHANNELS;

  // Next-state, counter, channel index and next output values.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_idx_nxt   = r_idx;
    w_nrst_nxt  = r_nrst;
    w_done_nxt  = r_done;
`ifdef NRST_SEQ_SWRST_EN
    if (SWRST_I) begin
      w_state_nxt = ST_ASSERT;
      w_cnt_nxt   = '0;
      w_idx_nxt   = '0;
      w_nrst_nxt  = '0;
      w_done_nxt  = 1'b0;
    end else begin
`endif
    case (r_state)
      ST_ASSERT: begin
        w_cnt_nxt  = '0;
        w_idx_nxt  = '0;
        w_nrst_nxt = '0;
        w_done_nxt = 1'b0;
        if (!w_sync_n) begin
          w_state_nxt = ST_ASSERT;
        end else if (HOLD_CYCLES != 32'sd0) begin
          w_state_nxt = ST_HOLD;
        end else begin
          w_nrst_nxt = w_nrst_shift[CHANNELS-1:0];
          if (CHANNELS == 32'sd1) begin
            w_state_nxt = ST_DONE;
            w_done_nxt  = 1'b1;
          end else begin
            w_state_nxt = ST_STEP;
          end
        end
      end
      ST_HOLD: begin
        if (w_hold_end) begin
          w_cnt_nxt  = '0;
          w_nrst_nxt = w_nrst_shift[CHANNELS-1:0];
          if (CHANNELS == 32'sd1) begin
            w_state_nxt = ST_DONE;
            w_done_nxt  = 1'b1;
          end else begin
            w_state_nxt = ST_STEP;
          end
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1'b1);
        end
      end
      ST_STEP: begin
        if (w_step_end) begin
          w_cnt_nxt  = '0;
          w_idx_nxt  = r_idx + IDX_W'(1'b1);
          w_nrst_nxt = w_nrst_shift[CHANNELS-1:0];
          if (w_last_ch) begin
            w_state_nxt = ST_DONE;
            w_done_nxt  = 1'b1;
          end else begin
            w_state_nxt = ST_STEP;
          end
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1'b1);
        end
      end
      ST_DONE: begin
        w_state_nxt = ST_DONE;
      end
      default: begin
        w_state_nxt = ST_ASSERT;
        w_cnt_nxt   = '0;
        w_idx_nxt   = '0;
        w_nrst_nxt  = '0;
        w_done_nxt  = 1'b0;
      end
    endcase
`ifdef NRST_SEQ_SWRST_EN
    end
`endif
  end

  // State, counters and registered outputs; all cleared asynchronously by NRST_I.
  always_ff @(posedge CLK_I or negedge NRST_I) begin
    if (!NRST_I) begin
      r_state <= ST_ASSERT;
      r_cnt   <= '0;
      r_idx   <= '0;
      r_nrst  <= '0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_idx   <= w_idx_nxt;
      r_nrst  <= w_nrst_nxt;
      r_done  <= w_done_nxt;
    end
  end

  assign NRST_O     = r_nrst;
  assign RST_DONE_O = r_done;

endmodule

// File: tb/tb_nrst_sequencer.sv
// Directed bench for nrst_sequencer: default instance plus a CHANNELS=1/HOLD=0/STAGES=3 instance.
`timescale 1ns/1ps
module tb_nrst_sequencer;

  localparam int T_STAGES = 2;
  localparam int T_HOLD   = 16;
  localparam int T_STEP   = 8;
  localparam int FIRST    = T_STAGES + 1 + T_HOLD;
  localparam int FIRST1   = 3 + 1 + 0;

  logic       clk;
  logic       rst_n;
  logic       swrst;
  logic [3:0] nrst;
  logic       done;
  logic [0:0] nrst1;
  logic       done1;

  int n_checks;
  int n_fail;

  nrst_sequencer u_dut (
    .CLK_I      (clk),
    .NRST_I     (rst_n),
`ifdef NRST_SEQ_SWRST_EN
    .SWRST_I    (swrst),
`endif
    .NRST_O     (nrst),
    .RST_DONE_O (done)
  );

  nrst_sequencer #(
    .STAGES      (3),
    .CHANNELS    (1),
    .HOLD_CYCLES (0),
    .STEP_CYCLES (8)
  ) u_dut1 (
    .CLK_I      (clk),
    .NRST_I     (rst_n),
`ifdef NRST_SEQ_SWRST_EN
    .SWRST_I    (1'b0),
`endif
    .NRST_O     (nrst1),
    .RST_DONE_O (done1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] exp_nrst(input int e, input int first);
    logic [3:0] v;
    for (int i = 0; i < 4; i++) v[i] = (e >= first + i * T_STEP);
    return v;
  endfunction

  task automatic check_zero(input string tag);
    check({tag, "_nrst"},  {28'd0, nrst},  32'd0);
    check({tag, "_done"},  {31'd0, done},  32'd0);
    check({tag, "_nrst1"}, {31'd0, nrst1}, 32'd0);
    check({tag, "_done1"}, {31'd0, done1}, 32'd0);
  endtask

  task automatic run_edges(input int from, input int to, input int first);
    for (int e = from; e <= to; e++) begin
      @(posedge clk);
      #1;
      check($sformatf("nrst@e%0d", e), {28'd0, nrst}, {28'd0, exp_nrst(e, first)});
      check($sformatf("done@e%0d", e), {31'd0, done}, {31'd0, (e >= first + 3 * T_STEP)});
      check($sformatf("nrst1@e%0d", e), {31'd0, nrst1}, {31'd0, (e >= FIRST1)});
      check($sformatf("done1@e%0d", e), {31'd0, done1}, {31'd0, (e >= FIRST1)});
    end
  endtask

  task automatic release_rst();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst_n    = 1'b0;
    swrst    = 1'b0;
    #23;
    check_zero("reset");

    // Nominal sequence from power-on reset.
    release_rst();
    run_edges(1, 45, FIRST);

    // Asynchronous assertion mid-sequence right after edge 30.
    rst_n = 1'b0;
    release_rst();
    run_edges(1, 30, FIRST);
    #1;
    rst_n = 1'b0;
    #1;
    check_zero("mid_async");
    #2;
    release_rst();
    run_edges(1, 45, FIRST);

    // 2 ns glitch between edges while done.
    #2;
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    #1;
    check_zero("glitch");
    run_edges(1, 45, FIRST);

    // Randomised assertion length, release phase and assertion point.
    for (int it = 0; it < 6; it++) begin
      #($urandom_range(1, 7));
      rst_n = 1'b0;
      #1;
      check_zero($sformatf("rnd%0d", it));
      #($urandom_range(1, 25));
      @(negedge clk);
      #($urandom_range(0, 3));
      rst_n = 1'b1;
      run_edges(1, $urandom_range(2, 50), FIRST);
    end

`ifdef NRST_SEQ_SWRST_EN
    // Soft reset for edges 50..52 after a completed sequence.
    #1;
    rst_n = 1'b0;
    release_rst();
    run_edges(1, 49, FIRST);
    swrst = 1'b1;
    run_edges(50, 52, 69);
    swrst = 1'b0;
    run_edges(53, 95, 69);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
